// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for the ALU divide op (3'b100), one quotient bit per clock.
// Optional macro DIV_SEQ_EARLY_EXIT_EN: skip iterations when dividend < divisor.
module div_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  localparam logic [2:0] OP_DIV = 3'b100;
  localparam int         CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     part_q, part_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               err_q, err_d;

  // Quotient bits are shifted into the vacated low end of the dividend register.
  logic [WIDTH+1:0]   shifted;
  logic               ge;
  logic [WIDTH:0]     part_step;

  assign shifted   = {part_q, dvd_q[WIDTH-1]};
  assign ge        = shifted >= (WIDTH+2)'(dvs_q);
  assign part_step = ge ? (WIDTH+1)'(shifted - (WIDTH+2)'(dvs_q)) : shifted[WIDTH:0];

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start && (op == OP_DIV)) begin
          dvd_d       = dividend;
          dvs_d       = divisor;
          part_d      = '0;
          cnt_d       = CNT_W'(WIDTH);
          quotient_d  = '0;
          remainder_d = '0;
          err_d       = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q == '0) begin
          err_d       = 1'b1;
          quotient_d  = '0;
          remainder_d = dvd_q;
          state_d     = DONE;
        end
`ifdef DIV_SEQ_EARLY_EXIT_EN
        else if (dvd_q < dvs_q) begin
          quotient_d  = '0;
          remainder_d = dvd_q;
          state_d     = DONE;
        end
`endif
        else begin
          state_d = ITER;
        end
      end
      ITER: begin
        dvd_d  = {dvd_q[WIDTH-2:0], ge};
        part_d = part_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          quotient_d  = {dvd_q[WIDTH-2:0], ge};
          remainder_d = part_step[WIDTH-1:0];
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err       = err_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl (WIDTH=4), including a full operand sweep.
// Expected early-exit latency follows DIV_SEQ_EARLY_EXIT_EN.
module tb_div_seq_ctrl;

  localparam int W = 4;
`ifdef DIV_SEQ_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  // Issues one divide and returns edges from T0 until done is seen; leaves the DUT back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op = 3'b100; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done === 1'b1) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'b000; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("[TB] FAIL reset_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("[TB] FAIL reset_rem: got %0d expected 0", remainder); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1; op = 3'b100; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_T0: got %0b expected 1", busy); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== (k <= 5)) begin errors++; $display("[TB] FAIL basic_busy_T%0d: got %0b expected %0b", k, busy, (k <= 5)); end
      checks++;
      if (done !== (k == 5)) begin errors++; $display("[TB] FAIL basic_done_T%0d: got %0b expected %0b", k, done, (k == 5)); end
    end
    checks++; if (quotient !== 4'd4) begin errors++; $display("[TB] FAIL basic_quot: got %0d expected 4", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("[TB] FAIL basic_rem: got %0d expected 1", remainder); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %0b expected 0", err); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(4'd7, 4'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL dz_err: got %0b expected 1", err); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("[TB] FAIL dz_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 4'd7) begin errors++; $display("[TB] FAIL dz_rem: got %0d expected 7", remainder); end
    run_op(4'd15, 4'd1, lat);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL div1_latency: got %0d expected 5", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL div1_err: got %0b expected 0", err); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("[TB] FAIL div1_quot: got %0d expected 15", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("[TB] FAIL div1_rem: got %0d expected 0", remainder); end
  endtask

  task automatic test_early_exit();
    int lat;
    run_op(4'd2, 4'd5, lat);
    checks++; if (lat !== EARLY_LAT) begin errors++; $display("[TB] FAIL early_latency: got %0d expected %0d", lat, EARLY_LAT); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("[TB] FAIL early_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("[TB] FAIL early_rem: got %0d expected 2", remainder); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL early_err: got %0b expected 0", err); end
  endtask

  task automatic test_ignore();
    int lat;
    run_op(4'd15, 4'd1, lat);
    @(negedge clk);
    start = 1'b1; op = 3'b011; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL badop_busy: got %0b expected 0", busy); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("[TB] FAIL badop_quot: got %0d expected 15", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("[TB] FAIL badop_rem: got %0d expected 0", remainder); end
    @(negedge clk);
    start = 1'b1; op = 3'b100; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = (k == 1 || k == 3); op = 3'b100; dividend = 4'd1; divisor = 4'd1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_done: got %0b expected 1", done); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("[TB] FAIL busy_start_quot: got %0d expected 4", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("[TB] FAIL busy_start_rem: got %0d expected 1", remainder); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_queued: got %0b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'b100; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %0b expected 0", done); end
    checks++; if (quotient !== 4'd0 || remainder !== 4'd0 || err !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_results: got q=%0d r=%0d e=%0b expected 0 0 0", quotient, remainder, err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_resume: got %0b expected 0", busy); end
    run_op(4'd9, 4'd2, lat);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL after_rst_latency: got %0d expected 5", lat); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("[TB] FAIL after_rst_quot: got %0d expected 4", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("[TB] FAIL after_rst_rem: got %0d expected 1", remainder); end
  endtask

  task automatic test_sweep();
    int lat;
    int exp_lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = i[W-1:0];
        b = j[W-1:0];
        exp_q   = (j == 0) ? 4'd0 : 4'(i / j);
        exp_r   = (j == 0) ? a    : 4'(i % j);
        exp_lat = (j == 0) ? 1 : ((i < j) ? EARLY_LAT : 5);
        run_op(a, b, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("[TB] FAIL sweep_latency %0d/%0d: got %0d expected %0d", i, j, lat, exp_lat); end
        checks++; if (quotient !== exp_q) begin errors++; $display("[TB] FAIL sweep_quot %0d/%0d: got %0d expected %0d", i, j, quotient, exp_q); end
        checks++; if (remainder !== exp_r) begin errors++; $display("[TB] FAIL sweep_rem %0d/%0d: got %0d expected %0d", i, j, remainder, exp_r); end
        checks++; if (err !== (j == 0)) begin errors++; $display("[TB] FAIL sweep_err %0d/%0d: got %0b expected %0b", i, j, err, (j == 0)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_early_exit();
    test_ignore();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequential controller that runs a WIDTH-bit unsigned restoring division for the ALU divide operation (op code 3'b100), one quotient bit per clock. It sits beside the ALU's combinational compare logic, accepts a start request, checks for divide-by-zero, sequences the shift/compare/subtract iterations and returns a registered quotient, remainder and error flag with a done pulse.

## Interface
- WIDTH, default 4: operand, quotient and remainder width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code; a request is accepted only when op == 3'b100.
- dividend  input  WIDTH  unsigned dividend; sampled on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results valid while high and after.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- err  output  1  divide-by-zero flag for the last completed operation.

## Operation
- States: IDLE, CHECK, ITER, DONE.
- IDLE: on an edge with start=1 and op=3'b100, latch operands, clear err, quotient and remainder, load step counter with WIDTH, go to CHECK. start with any other op is ignored.
- CHECK: divisor==0 → err=1, quotient=0, remainder=latched dividend, go to DONE. Otherwise go to ITER.
- ITER: partial remainder register is WIDTH+1 bits. Each cycle: shift {partial, dividend MSB} left by one, shift dividend register left; if partial ≥ divisor, subtract divisor and shift in quotient bit 1, else 0. Decrement counter; after the WIDTH-th step write quotient/remainder outputs and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy=1 (no queuing, no abort).
- quotient, remainder, err hold their values until the next accepted request.
- Reset (any time, including mid-operation): state IDLE, busy=0, done=0, err=0, quotient=0, remainder=0, internal registers 0; the in-flight operation is discarded.

## Timing
- Accepting edge = T0; busy rises after T0.
- Divide-by-zero: DONE entered at T1; done high for the cycle after T1.
- Normal: ITER entered at T1, steps on edges T2..T(WIDTH+1), DONE entered at T(WIDTH+1); done high for the cycle after T(WIDTH+1). WIDTH=4: done after T5.
- busy falls at the edge leaving DONE; a new start is accepted on the edge after that (earliest back-to-back spacing: WIDTH+3 edges).
- Outputs are purely registered; no combinational input-to-output path.

## Configuration
- DIV_SEQ_EARLY_EXIT_EN defined: in CHECK, a nonzero divisor with dividend < divisor skips ITER: quotient=0, remainder=dividend, DONE entered at T1 (same latency as divide-by-zero), err=0.
- Undefined: such operations run the full WIDTH iterations; results are identical, only latency differs.

## Test plan
- WIDTH=4, 13/3, op=3'b100 → done pulse after T5, quotient=4, remainder=1, err=0, busy high T0→T6.
- 7/0 → done after T1, err=1, quotient=0, remainder=7; next 15/1 → err=0, quotient=15, remainder=0.
- 2/5 → quotient=0, remainder=2; done after T1 with DIV_SEQ_EARLY_EXIT_EN, after T5 without.
- start pulses during ITER and start with op=3'b011 in IDLE → ignored; outputs and state unchanged.
- rst_n low during ITER of 9/2 → all outputs 0 immediately, IDLE; following 9/2 → quotient=4, remainder=1.
- Exhaustive sweep of all 256 dividend/divisor pairs → results match dividend/divisor and dividend%divisor; divisor 0 → err=1.
